// File: rtl/cam_ctrl.sv
// Purpose : command sequencer in front of the credential CAM; owns the valid bitmap and slot allocation.
// Latency : accept -> rsp_valid in LOOKUP_LATENCY+3 cycles (LOOKUP_LATENCY+4 on a written insert, 1 on reserved op).
// Backpr. : one command in flight; cmd_ready only in IDLE, response held stable until rsp_ready.
// Ports   : cmd_* (valid/ready request in), rsp_* (valid/ready status out), cam_* (CAM search/write
//           port), count/full (occupancy of the valid bitmap). rst is asynchronous, active-low.
module cam_ctrl #(
    parameter int DATA_WIDTH     = 4,
    parameter int ADDR_WIDTH     = 2,
    parameter int LOOKUP_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_status,
    output logic [ADDR_WIDTH-1:0] rsp_addr,
    output logic                  cam_write_enable,
    output logic [ADDR_WIDTH-1:0] cam_write_addr,
    output logic [DATA_WIDTH-1:0] cam_din,
    output logic                  cam_start,
    input  logic                  cam_match,
    input  logic [ADDR_WIDTH-1:0] cam_match_addr,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full
);
    localparam int ENTRIES = 2**ADDR_WIDTH;
    localparam int LCW     = (LOOKUP_LATENCY < 1) ? 1 : $clog2(LOOKUP_LATENCY + 1);
    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    localparam logic [1:0] OP_LOOKUP = 2'b00;
    localparam logic [1:0] OP_INSERT = 2'b01;
    localparam logic [1:0] OP_DELETE = 2'b10;
    localparam logic [1:0] OP_RSV    = 2'b11;

    localparam logic [1:0] ST_OK   = 2'b00;
    localparam logic [1:0] ST_NF   = 2'b01;
    localparam logic [1:0] ST_DUP  = 2'b10;
    localparam logic [1:0] ST_FULL = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_SEARCH, S_DECIDE, S_WRITE, S_RESP} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             op_q, op_d;
    logic [DATA_WIDTH-1:0]  key_q, key_d;
    logic [LCW-1:0]         lat_q, lat_d;
    logic                   match_q, match_d;
    logic [ADDR_WIDTH-1:0]  maddr_q, maddr_d;
    logic [ADDR_WIDTH-1:0]  target_q, target_d;
    logic [ENTRIES-1:0]     valid_q, valid_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [1:0]             status_q, status_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

    logic                   free_found;
    logic [ADDR_WIDTH-1:0]  free_idx;
    logic                   valid_hit;

    // cmd_ready is gated by rst so the controller advertises nothing while held in reset.
    assign cmd_ready  = rst && (state_q == S_IDLE);
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_status = status_q;
    assign rsp_addr   = addr_q;
    assign count      = count_q;
    assign full       = (count_q == (ADDR_WIDTH+1)'(ENTRIES));

    // The CAM has no valid notion: a match only counts if the bitmap agrees.
    assign valid_hit  = match_q && valid_q[maddr_q];

    // Lowest free slot; scanning downwards leaves the lowest index last.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = ADDR_WIDTH'(i);
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        key_d            = key_q;
        lat_d            = lat_q;
        match_d          = match_q;
        maddr_d          = maddr_q;
        target_d         = target_q;
        valid_d          = valid_q;
        count_d          = count_q;
        status_d         = status_q;
        addr_d           = addr_q;
        cam_start        = 1'b0;
        cam_write_enable = 1'b0;
        cam_write_addr   = '0;
        cam_din          = '0;

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    op_d  = cmd_op;
                    key_d = cmd_data;
                    if (cmd_op == OP_RSV) begin
                        status_d = ST_FULL;
                        addr_d   = '0;
                        state_d  = S_RESP;
                    end else begin
                        lat_d   = LCW'(LOOKUP_LATENCY);
                        state_d = S_SEARCH;
                    end
                end
            end
            S_SEARCH: begin
                cam_din   = key_q;
                cam_start = 1'b1;
                if (lat_q == '0) begin
                    match_d = cam_match;
                    maddr_d = cam_match_addr;
                    state_d = S_DECIDE;
                end else begin
                    lat_d = lat_q - LCW'(1);
                end
            end
            S_DECIDE: begin
                state_d  = S_RESP;
                status_d = ST_NF;
                addr_d   = '0;
                case (op_q)
                    OP_LOOKUP: begin
                        if (valid_hit) begin
                            status_d = ST_OK;
                            addr_d   = maddr_q;
                        end
                    end
                    OP_DELETE: begin
                        if (valid_hit) begin
                            valid_d[maddr_q] = 1'b0;
                            count_d          = count_q - CNT_ONE;
                            status_d         = ST_OK;
                            addr_d           = maddr_q;
                        end
                    end
                    OP_INSERT: begin
                        if (valid_hit) begin
                            status_d = ST_DUP;
                        end else if (match_q) begin
                            // Reusing the lowest stale copy keeps valid keys at their lowest CAM address.
                            target_d = maddr_q;
                            state_d  = S_WRITE;
                        end else if (full || !free_found) begin
                            status_d = ST_FULL;
                        end else begin
                            target_d = free_idx;
                            state_d  = S_WRITE;
                        end
                    end
                    default: status_d = ST_FULL;
                endcase
            end
            S_WRITE: begin
                cam_write_enable  = 1'b1;
                cam_write_addr    = target_q;
                cam_din           = key_q;
                valid_d[target_q] = 1'b1;
                count_d           = count_q + CNT_ONE;
                status_d          = ST_OK;
                addr_d            = target_q;
                state_d           = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            key_q    <= '0;
            lat_q    <= '0;
            match_q  <= 1'b0;
            maddr_q  <= '0;
            target_q <= '0;
            valid_q  <= '0;
            count_q  <= '0;
            status_q <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_q    <= key_d;
            lat_q    <= lat_d;
            match_q  <= match_d;
            maddr_q  <= maddr_d;
            target_q <= target_d;
            valid_q  <= valid_d;
            count_q  <= count_d;
            status_q <= status_d;
            addr_q   <= addr_d;
        end
    end
endmodule

// File: tb/tb_cam_ctrl.sv
// Purpose : self-checking bench for cam_ctrl with a behavioural CAM and a set-level reference model.
// Latency : n/a (bench).
// Backpr. : exercises rsp_ready hold-off and command gating.
module tb_cam_ctrl;
    localparam int DW = 4;
    localparam int AW = 2;
    localparam int LL = 1;
    localparam int ENTRIES = 2**AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [1:0]    rsp_status;
    logic [AW-1:0] rsp_addr;
    logic          cam_write_enable;
    logic [AW-1:0] cam_write_addr;
    logic [DW-1:0] cam_din;
    logic          cam_start;
    logic          cam_match = 1'b0;
    logic [AW-1:0] cam_match_addr = '0;
    logic [AW:0]   count;
    logic          full;

    int tests = 0;
    int fails = 0;

    cam_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOOKUP_LATENCY(LL)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status), .rsp_addr(rsp_addr),
        .cam_write_enable(cam_write_enable), .cam_write_addr(cam_write_addr), .cam_din(cam_din),
        .cam_start(cam_start), .cam_match(cam_match), .cam_match_addr(cam_match_addr),
        .count(count), .full(full)
    );

    always #5 clk = ~clk;

    // Behavioural CAM: one-edge search latency, lowest matching address wins, no reset of contents.
    logic [DW-1:0] cam_mem [ENTRIES] = '{default: '0};
    always @(posedge clk) begin
        if (cam_start) begin
            cam_match      <= 1'b0;
            cam_match_addr <= '0;
            for (int i = ENTRIES - 1; i >= 0; i--) begin
                if (cam_mem[i] == cam_din) begin
                    cam_match      <= 1'b1;
                    cam_match_addr <= AW'(i);
                end
            end
        end
        if (cam_write_enable) cam_mem[cam_write_addr] <= cam_din;
    end

    // Reference model: predicted CAM contents plus the set of live entries.
    logic [DW-1:0] ref_mem [ENTRIES] = '{default: '0};
    bit            ref_vld [ENTRIES] = '{default: 1'b0};

    function automatic int model_count();
        int c = 0;
        for (int i = 0; i < ENTRIES; i++) c += int'(ref_vld[i]);
        return c;
    endfunction

    task automatic model(input logic [1:0] op, input logic [DW-1:0] key,
                         output logic [1:0] st, output logic [AW-1:0] ad,
                         output int wr, output logic [AW-1:0] wa, output int lat);
        int hit_at = -1;
        int free_at = -1;
        st = 2'b01; ad = '0; wr = 0; wa = '0; lat = LL + 3;
        if (op == 2'b11) begin
            st = 2'b11; lat = 1;
            return;
        end
        for (int i = 0; i < ENTRIES; i++) if (hit_at < 0 && ref_mem[i] == key) hit_at = i;
        for (int i = 0; i < ENTRIES; i++) if (free_at < 0 && !ref_vld[i]) free_at = i;
        if (op == 2'b00 || op == 2'b10) begin
            if (hit_at >= 0 && ref_vld[hit_at]) begin
                st = 2'b00; ad = AW'(hit_at);
                if (op == 2'b10) ref_vld[hit_at] = 1'b0;
            end
        end else begin
            if (hit_at >= 0 && ref_vld[hit_at]) st = 2'b10;
            else if (hit_at < 0 && model_count() == ENTRIES) st = 2'b11;
            else begin
                wa = AW'((hit_at >= 0) ? hit_at : free_at);
                ref_mem[wa] = key; ref_vld[wa] = 1'b1;
                st = 2'b00; ad = wa; wr = 1; lat = LL + 4;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Issues one command starting at a negedge and returns what the DUT did with it.
    task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] key, input int hold,
                           output logic [1:0] st, output logic [AW-1:0] ad,
                           output int wrs, output logic [AW-1:0] wa, output int lat);
        int guard = 0;
        wrs = 0; wa = '0; lat = 0;
        while (!cmd_ready && guard < 20) begin @(negedge clk); guard++; end
        check("cmd_ready_before", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = key;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        do begin
            @(negedge clk); lat++;
            if (cam_write_enable) begin
                wrs++; wa = cam_write_addr;
                check("wr_din", cam_din, key);
            end
        end while (!rsp_valid && lat < 30);
        if (!rsp_valid) check("rsp_timeout", 0, 1);
        st = rsp_status; ad = rsp_addr;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_status", rsp_status, st);
            check("hold_addr", rsp_addr, ad);
            check("hold_cmd_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("cmd_ready_after", cmd_ready, 1);
    endtask

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] key;
        int            hold;
        logic [1:0]    st;
        logic [AW-1:0] ad;
        int            cnt;
        logic          full;
        int            wr;
        int            lat;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(logic [1:0] op, logic [DW-1:0] key, int hold, logic [1:0] st,
                                logic [AW-1:0] ad, int cnt, logic f, int wr, int lat);
        vec_t v;
        v.op = op; v.key = key; v.hold = hold; v.st = st; v.ad = ad;
        v.cnt = cnt; v.full = f; v.wr = wr; v.lat = lat;
        vecs.push_back(v);
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests so far", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]    st, est;
        logic [AW-1:0] ad, ead, wa, ewa;
        int            wrs, ewr, lat, elat, any_rsp;

        rst = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; rsp_ready = 1'b0;

        // op, key, hold, status, addr, count, full, writes, latency
        add(2'b00, 4'h0, 0, 2'b01, 2'd0, 0, 1'b0, 0, LL+3);
        add(2'b01, 4'h5, 0, 2'b00, 2'd0, 1, 1'b0, 1, LL+4);
        add(2'b01, 4'h9, 0, 2'b00, 2'd1, 2, 1'b0, 1, LL+4);
        add(2'b01, 4'hA, 0, 2'b00, 2'd2, 3, 1'b0, 1, LL+4);
        add(2'b01, 4'h3, 0, 2'b00, 2'd3, 4, 1'b1, 1, LL+4);
        add(2'b01, 4'hC, 0, 2'b11, 2'd0, 4, 1'b1, 0, LL+3);
        add(2'b01, 4'h9, 0, 2'b10, 2'd0, 4, 1'b1, 0, LL+3);
        add(2'b00, 4'h9, 0, 2'b00, 2'd1, 4, 1'b1, 0, LL+3);
        add(2'b10, 4'h9, 0, 2'b00, 2'd1, 3, 1'b0, 0, LL+3);
        add(2'b00, 4'h9, 0, 2'b01, 2'd0, 3, 1'b0, 0, LL+3);
        add(2'b01, 4'hC, 0, 2'b00, 2'd1, 4, 1'b1, 1, LL+4);
        add(2'b01, 4'h9, 0, 2'b11, 2'd0, 4, 1'b1, 0, LL+3);
        add(2'b10, 4'hA, 0, 2'b00, 2'd2, 3, 1'b0, 0, LL+3);
        add(2'b01, 4'hA, 5, 2'b00, 2'd2, 4, 1'b1, 1, LL+4);
        add(2'b11, 4'h0, 1, 2'b11, 2'd0, 4, 1'b1, 0, 1);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_cam_start", cam_start, 0);
        check("rst_cam_we", cam_write_enable, 0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_cmd_ready", cmd_ready, 1);

        // Directed table
        foreach (vecs[i]) begin
            model(vecs[i].op, vecs[i].key, est, ead, ewr, ewa, elat);
            run_cmd(vecs[i].op, vecs[i].key, vecs[i].hold, st, ad, wrs, wa, lat);
            check($sformatf("vec%0d_status", i), st, vecs[i].st);
            check($sformatf("vec%0d_addr", i), ad, vecs[i].ad);
            check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
            check($sformatf("vec%0d_full", i), full, vecs[i].full);
            check($sformatf("vec%0d_writes", i), wrs, vecs[i].wr);
            if (vecs[i].wr != 0) check($sformatf("vec%0d_wr_addr", i), wa, vecs[i].ad);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Reset during SEARCH of an insert
        cmd_valid = 1'b1; cmd_op = 2'b01; cmd_data = 4'h7;
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
        @(negedge clk);
        check("mid_search_cam_start", cam_start, 1);
        rst = 1'b0;
        #1;
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_rsp_status", rsp_status, 0);
        check("mid_rst_rsp_addr", rsp_addr, 0);
        check("mid_rst_cam_start", cam_start, 0);
        check("mid_rst_cam_we", cam_write_enable, 0);
        check("mid_rst_cam_din", cam_din, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_full", full, 0);
        for (int i = 0; i < ENTRIES; i++) ref_vld[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        any_rsp = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid) any_rsp = 1;
        end
        check("no_rsp_after_rst", any_rsp, 0);
        check("count_after_rst", count, 0);
        model(2'b00, 4'h7, est, ead, ewr, ewa, elat);
        run_cmd(2'b00, 4'h7, 0, st, ad, wrs, wa, lat);
        check("lookup_after_rst", st, 2'b01);
        check("lookup_after_rst_addr", ad, 0);

        // Randomized commands against the reference model
        for (int n = 0; n < 150; n++) begin
            int            sel;
            logic [1:0]    op;
            logic [DW-1:0] key;
            sel = $urandom_range(0, 9);
            op  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
            key = DW'($urandom_range(0, 7));
            model(op, key, est, ead, ewr, ewa, elat);
            run_cmd(op, key, $urandom_range(0, 2), st, ad, wrs, wa, lat);
            check($sformatf("rnd%0d_status", n), st, est);
            check($sformatf("rnd%0d_addr", n), ad, ead);
            check($sformatf("rnd%0d_writes", n), wrs, ewr);
            if (ewr != 0) check($sformatf("rnd%0d_wr_addr", n), wa, ewa);
            check($sformatf("rnd%0d_latency", n), lat, elat);
            check($sformatf("rnd%0d_count", n), count, model_count());
            check($sformatf("rnd%0d_full", n), full, model_count() == ENTRIES);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Command sequencer placed directly upstream of the credential CAM.
- Accepts lookup, insert and delete requests over a valid/ready handshake.
- Drives the CAM search and write ports and owns the per-entry valid bitmap and free-slot allocation, since the CAM itself has no valid or erase notion.
- Returns one status response per command over a second valid/ready handshake.

Parameters:
- DATA_WIDTH, 4: key width; matches the CAM data width.
- ADDR_WIDTH, 2: log2 of CAM depth; ENTRIES = 2**ADDR_WIDTH.
- LOOKUP_LATENCY, 1: clock edges from cam_din/cam_start stable to cam_match valid.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  controller can accept a command.
- cmd_op  in  2  00 lookup, 01 insert, 10 delete, 11 reserved.
- cmd_data  in  DATA_WIDTH  key.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_status  out  2  00 OK, 01 NOT_FOUND, 10 DUPLICATE, 11 FULL/ILLEGAL.
- rsp_addr  out  ADDR_WIDTH  entry address; 0 unless status OK.
- cam_write_enable  out  1  CAM write strobe.
- cam_write_addr  out  ADDR_WIDTH  CAM write address.
- cam_din  out  DATA_WIDTH  CAM search/write data.
- cam_start  out  1  CAM search gate.
- cam_match  in  1  CAM hit.
- cam_match_addr  in  ADDR_WIDTH  lowest matching CAM address.
- count  out  ADDR_WIDTH+1  number of valid entries.
- full  out  1  count == ENTRIES.

Behaviour:

Reset (rst=0, asynchronous):
- State goes to IDLE.
- Valid bitmap, count, rsp_*, cam_write_enable and cam_start all go to 0.
- full goes to 0.
- cmd_ready goes to 1 once rst deasserts.
- Reset mid-command abandons the command with no response.
- CAM contents are not cleared. Valid bitmap 0 makes all stale contents invisible.

Handshake:
- A command is accepted on a clock edge where cmd_valid & cmd_ready.
- On acceptance, cmd_op and cmd_data are latched.
- cmd_ready = 1 only in IDLE, so only one command is in flight.
- The response holds stable while rsp_valid & !rsp_ready.
- The response is consumed on an edge where rsp_valid & rsp_ready. The FSM then returns to IDLE.
- cmd_ready is reasserted the cycle after consumption. There is no command/response overlap.

FSM states: IDLE, SEARCH, DECIDE, WRITE, RESP.
- IDLE: on accept, go to SEARCH. A reserved op goes directly to RESP with status 11.
- SEARCH: cam_din = latched key, cam_start = 1.
  - Lasts LOOKUP_LATENCY+1 cycles, tracked by a down-counter.
  - cam_match and cam_match_addr are registered on the final SEARCH edge.
  - A hit counts only if valid[cam_match_addr] = 1.
- DECIDE:
  - Lookup: valid hit gives OK/addr; otherwise NOT_FOUND.
  - Delete: valid hit clears valid[addr], decrements count, gives OK/addr; otherwise NOT_FOUND.
  - Insert, valid hit: DUPLICATE, no write.
  - Insert, stale hit (cam_match=1, valid bit 0): target = cam_match_addr, go to WRITE.
  - Insert, no hit: if full, status FULL with no write; else target = lowest index with valid=0, go to WRITE.
- WRITE (one cycle): cam_write_enable=1, cam_write_addr=target, cam_din=key. On the edge, set valid[target], increment count, status OK/target.
- RESP: rsp_valid=1.

Latency from the accept edge to rsp_valid high:
- Lookup, delete and insert-error: LOOKUP_LATENCY+3 cycles.
- Successful insert: LOOKUP_LATENCY+4 cycles.
- Reserved op: 1 cycle.

Invariant:
- Reuse of the lowest stale match keeps any valid key at the lowest CAM address holding that key. The CAM priority encoder therefore never hides a valid entry behind a stale one.

Combinational constraints:
- cam_start is 0 outside SEARCH; cam_write_enable is 0 outside WRITE.
- count never wraps. full and count are updated in the same cycle.
- Deleting the last entry gives count=0. Insert into a full table does not change state.

Test Plan:
- Reset, then lookup 0x0 -> NOT_FOUND, addr 0, count 0. Holds even though CAM RAM may contain 0x0.
- Insert 0x5, 0x9, 0xA, 0x3 -> OK at addr 0,1,2,3; full=1, count=4. Then insert 0xC -> FULL, no cam_write_enable pulse.
- Insert 0x9 when 0x9 is present -> DUPLICATE, addr 0; then lookup 0x9 -> OK, addr 1.
- Delete 0x9 (addr 1) -> OK/1, count 3. Lookup 0x9 -> NOT_FOUND. Insert 0xC -> OK/1 (lowest free). Insert 0x9 -> FULL.
- Stale reuse: delete 0xA (addr 2), reinsert 0xA -> OK/2 via stale hit, write at addr 2. Hold rsp_ready=0 for 5 cycles -> rsp fields stable, cmd_ready=0 throughout.
- Assert rst low during SEARCH of an insert -> all outputs 0 immediately, no response after release, count 0, and a subsequent lookup of that key -> NOT_FOUND.
